// File: rtl/fifo_pkg.sv
// ============================================================================
// Module   : fifo_pkg
// Purpose  : Shared FSM state encoding and parameter defaults for the packer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

   typedef enum logic [0:0] {
      FILL = 1'b0,
      OUT  = 1'b1
   } state_t;

   localparam int WORD_BYTES_DEF = 4;
   localparam int CNT_W_DEF      = 16;

endpackage : fifo_pkg

`default_nettype wire

// File: rtl/fifo_rd_packer.sv
// ============================================================================
// Module   : fifo_rd_packer
// Purpose  : Pops bytes from a FWFT FIFO and packs them little-endian into
//            WORD_BYTES-wide words with valid/ready output and flush support.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_rd_packer
   import fifo_pkg::*;
#(
   parameter int WORD_BYTES = WORD_BYTES_DEF,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic                    rclk,
   input  logic                    rrst_n,
   input  logic                    rempty,
   input  logic [7:0]              rdata,
   output logic                    rinc,
   input  logic                    flush,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [8*WORD_BYTES-1:0] out_data,
   output logic [2:0]              out_bytes,
   output logic [CNT_W-1:0]        word_cnt
);

   localparam int                BC_W   = $clog2(WORD_BYTES + 1);
   localparam logic [BC_W-1:0]   c_LAST = BC_W'(WORD_BYTES - 1);

   state_t                  r_state;
   logic [BC_W-1:0]         r_cnt;
   logic [8*WORD_BYTES-1:0] r_data;
   logic [2:0]              r_bytes;
   logic                    r_valid;
   logic [CNT_W-1:0]        r_wcnt;

   logic                    w_pop;

   // Pop is combinational so the head byte is consumed on the same edge it is stored.
   assign w_pop = rrst_n & ~rempty &
                  ((r_state == FILL) | ((r_state == OUT) & out_ready));

   assign rinc      = w_pop;
   assign out_valid = r_valid;
   assign out_data  = r_data;
   assign out_bytes = r_bytes;
   assign word_cnt  = r_wcnt;

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         r_state <= FILL;
         r_cnt   <= '0;
         r_data  <= '0;
         r_bytes <= '0;
         r_valid <= 1'b0;
         r_wcnt  <= '0;
      end else begin
         case (r_state)
            FILL: begin
               if (w_pop) begin
                  for (int k = 0; k < WORD_BYTES; k++) begin
                     if (r_cnt == BC_W'(k)) r_data[8*k +: 8] <= rdata;
                  end
                  if ((r_cnt == c_LAST) || flush) begin
                     r_state <= OUT;
                     r_valid <= 1'b1;
                     r_bytes <= 3'(r_cnt + 1'b1);
                     r_cnt   <= '0;
                  end else begin
                     r_cnt   <= r_cnt + 1'b1;
                  end
               end else if (flush && (r_cnt != '0)) begin
                  r_state <= OUT;
                  r_valid <= 1'b1;
                  r_bytes <= 3'(r_cnt);
                  r_cnt   <= '0;
               end
            end
            OUT: begin
               if (out_ready) begin
                  r_wcnt <= r_wcnt + 1'b1;
                  // Upper lanes start cleared so a later flush leaves them zero.
                  r_data <= '0;
                  if (w_pop) begin
                     r_data[7:0] <= rdata;
                     if (WORD_BYTES == 1) begin
                        r_bytes <= 3'd1;
                     end else begin
                        r_state <= FILL;
                        r_valid <= 1'b0;
                        r_bytes <= '0;
                        r_cnt   <= BC_W'(1);
                     end
                  end else begin
                     r_state <= FILL;
                     r_valid <= 1'b0;
                     r_bytes <= '0;
                     r_cnt   <= '0;
                  end
               end
            end
         endcase
      end
   end

endmodule : fifo_rd_packer

`default_nettype wire

// File: doc/fifo_rd_packer.md
FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

Interface
REQ-001 The block SHALL use one clock, rclk, and one reset, rrst_n, which is asynchronous and active-low.
REQ-002 Parameter WORD_BYTES, default 4: number of bytes packed per output word.
REQ-003 Parameter CNT_W, default 16: width of the accepted-word counter.
REQ-004 rclk  input  1  read-domain clock; all state updates on its rising edge.
REQ-005 rrst_n  input  1  asynchronous active-low reset.
REQ-006 rempty  input  1  FIFO empty flag; rdata is valid whenever rempty=0.
REQ-007 rdata  input  8  FIFO head byte (first-word fall-through).
REQ-008 rinc  output  1  FIFO pop strobe; pops the head byte on the same rclk edge.
REQ-009 flush  input  1  request to emit a partially filled word.
REQ-010 out_valid  output  1  packed word available.
REQ-011 out_ready  input  1  downstream accepts the word when out_valid=1.
REQ-012 out_data  output  8*WORD_BYTES  packed word, little-endian.
REQ-013 out_bytes  output  3  number of valid bytes in out_data, 1..WORD_BYTES.
REQ-014 word_cnt  output  CNT_W  number of accepted words.

Function
REQ-015 Pop condition: rinc = rrst_n & ~rempty & (state==FILL | (state==OUT & out_ready)); there is no other pop path.
REQ-016 A pop is the rclk edge where rinc=1; rinc SHALL never be 1 while rempty=1.
REQ-017 FSM states: FILL (collecting bytes) and OUT (word held, out_valid=1).
REQ-018 Byte lane: the k-th byte popped into a word (k=0..WORD_BYTES-1) SHALL land in out_data[8k+7:8k].
REQ-019 FILL->OUT: when the pop of lane WORD_BYTES-1 occurs; out_bytes=WORD_BYTES.
REQ-020 FILL->OUT on flush: if flush=1 in FILL and (byte count>0 or a pop occurs that edge), the word SHALL be emitted with out_bytes = count including that pop.
REQ-021 Flush edge cases: unused upper lanes SHALL be zero; flush with count=0 and no pop is ignored; flush in OUT is ignored.
REQ-022 OUT: out_valid=1 and out_data/out_bytes SHALL stay stable until out_valid & out_ready.
REQ-023 OUT->FILL on acceptance; a byte popped on that same edge SHALL become lane 0 of the next word (count=1), with all other lanes cleared.
REQ-024 Throughput: sustained non-empty FIFO with out_ready=1 SHALL yield one accepted word every WORD_BYTES cycles with no bubble.
REQ-025 Latency: out_valid SHALL rise on the edge of the final pop of the word (zero extra cycles).
REQ-026 word_cnt SHALL increment by 1 on every out_valid & out_ready edge and wrap from 2^CNT_W-1 to 0.
REQ-027 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-028 While rrst_n=0: state=FILL, byte count=0, out_valid=0, out_data=0, out_bytes=0, word_cnt=0, rinc=0.
REQ-029 A reset asserted mid-word or in OUT SHALL discard the partial or held word without a pop or acceptance.
REQ-030 The first pop after deassertion SHALL occur no earlier than the first rclk edge with rrst_n=1.

Structure
REQ-031 A shared package fifo_pkg SHALL hold the FSM state enum (FILL, OUT), the WORD_BYTES default, and the CNT_W default.
REQ-032 No sub-module is natural; the block SHALL be flat (FSM, lane register, byte counter, word counter).

Verification
REQ-033 Packing: push 01..08, out_ready=1, no flush -> words 0x04030201 then 0x08070605, each with out_bytes=4; word_cnt=2; 8 pops.
REQ-034 Backpressure: push 01..08, out_ready=0 for 10 cycles, then 1 -> 0x04030201 held stable; rinc=0 while held; then the second word arrives with no loss.
REQ-035 Flush: push 0A,0B, wait for rempty, pulse flush -> out_data=0x00000B0A, out_bytes=2; flush with empty FIFO and count 0 -> no output.
REQ-036 Concurrent accept/pop: hold word 1, push 05, raise out_ready -> 05 lands in lane 0 of word 2 on the accept edge.
REQ-037 Reset mid-word: pop 3 bytes, assert rrst_n -> all outputs 0; after release, 11..14 -> 0x14131211.
REQ-038 Wrap (CNT_W=4 override): 17 accepted words -> word_cnt reads 1.
